// File: rtl/rsa_seq_pkg.sv
// rsa_seq_pkg
//   Shared definitions for the RSA run sequencer:
//   - seq_state_t : run-controller FSM states (IDLE, ARM, RUN, DONE)
//   - ADDR_W_DEF  : default memory address width
//   - DATA_W_DEF  : default memory data width
package rsa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_mux.sv
// mem_port_mux
//   Combinational selector for the single-port data RAM. When cpu_owns is
//   high the CPU data-memory port drives the RAM. Otherwise the host port
//   does, and a write reaches the RAM only when the host access was granted.
//
// Ports:
//   cpu_owns                               in  : 1 = CPU owns the RAM
//   cpu_mem_write, cpu_addr, cpu_wdata     in  : CPU memory port
//   host_gnt, host_we, host_addr,
//   host_wdata                             in  : host memory port
//   mem_we, mem_addr, mem_wdata            out : to data RAM
module mem_port_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_owns,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              host_gnt,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (cpu_owns) begin
      mem_we    = cpu_mem_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      // An ungranted host write must never reach the RAM.
      mem_we = host_gnt && host_we;
    end
  end

endmodule

// File: rtl/rsa_run_sequencer.sv
// rsa_run_sequencer
//   Run controller for the RSA pipeline CPU. It holds the CPU in reset while
//   the host loads the shared data RAM, pulses cpu_start, and gives the CPU
//   exclusive RAM ownership until FlagZero (or, optionally, the watchdog)
//   ends the run. The RAM then returns to the host for result readout.
//
// Configuration macro:
//   SEQ_WATCHDOG_EN : when defined, a RUN-cycle watchdog ends runs that
//                     last MAX_CYCLES cycles and raises timeout. When
//                     undefined, there is no counter and timeout is tied 0.
//
// Ports:
//   clk, reset                          in  : clock, sync active-high reset
//   go                                  in  : run request (IDLE/DONE only)
//   host_req/we/addr/wdata              in  : host memory request
//   host_gnt                            out : host access accepted this cycle
//   host_rvalid, host_rdata             out : read data, 1 cycle after grant
//   busy, done, timeout                 out : run status
//   cpu_reset, cpu_start                out : CPU control
//   cpu_flag_zero                       in  : CPU completion flag
//   cpu_mem_write, cpu_addr, cpu_wdata  in  : CPU memory port
//   mem_we, mem_addr, mem_wdata         out : RAM port
//   mem_rdata                           in  : RAM read data (1-cycle latency)
//   dbg_state                           out : current FSM state
//
// Host handshake: host_req is a request that is accepted (host_gnt=1) in the
// same cycle, only in IDLE/DONE, and only when go is low. There is no
// back-pressure beyond the grant. A granted read returns host_rvalid=1 with
// host_rdata on the following cycle. Back-to-back reads are accepted.
module rsa_run_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              cpu_reset,
  output logic              cpu_start,
  input  logic              cpu_flag_zero,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output seq_state_t        dbg_state
);

  seq_state_t state;
  logic       host_side;

`ifdef SEQ_WATCHDOG_EN
  localparam int              CNT_W   = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign dbg_state = state;
  assign host_side = (state == IDLE) || (state == DONE);

  // go wins over a simultaneous host request: the RAM changes owner on the
  // very edge that samples go.
  assign host_gnt = host_side && host_req && !go;

  // Gate read data so host_rdata reads 0 whenever no read is being returned.
  assign host_rdata = host_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_reset   <= 1'b1;
      cpu_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      host_rvalid <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      host_rvalid <= host_gnt && !host_we;
      cpu_start   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state     <= ARM;
            cpu_reset <= 1'b0;
            cpu_start <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
          end
        end
        ARM: begin
          state <= RUN;
        end
        RUN: begin
          // The flag is checked first so it beats a same-cycle expiry.
          if (cpu_flag_zero) begin
            state     <= DONE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state     <= DONE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            // The counter cannot pass WD_LAST because RUN exits there.
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  mem_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .cpu_owns      (busy),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .host_gnt      (host_gnt),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata)
  );

endmodule

// File: tb/tb_rsa_run_sequencer.sv
// tb_rsa_run_sequencer
//   Directed bench for rsa_run_sequencer with a behavioural synchronous RAM.
//   Works with SEQ_WATCHDOG_EN defined or undefined.
module tb_rsa_run_sequencer;
  import rsa_seq_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXC = 48;

  logic          clk;
  logic          reset;
  logic          go;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          cpu_reset;
  logic          cpu_start;
  logic          cpu_flag_zero;
  logic          cpu_mem_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  seq_state_t    dbg_state;

  int total = 0;
  int bad   = 0;

  rsa_run_sequencer #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .cpu_reset     (cpu_reset),
    .cpu_start     (cpu_start),
    .cpu_flag_zero (cpu_flag_zero),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model (256 words, 1-cycle read) ----------------
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_done_state(input string tag, input logic exp_to);
    check_eq({tag, "_state"}, dbg_state, DONE);
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_timeout"}, timeout, exp_to);
    check_eq({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    reset = 1'b1; go = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    cpu_flag_zero = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step_n(2);

    // Reset values
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_gnt", host_gnt, 1'b0);
    check_eq("rst_rvalid", host_rvalid, 1'b0);
    check_eq("rst_rdata", host_rdata, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_timeout", timeout, 1'b0);
    check_eq("rst_cpu_reset", cpu_reset, 1'b1);
    check_eq("rst_cpu_start", cpu_start, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    reset = 1'b0;
    step();

    // Host write then read-back in IDLE
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'hA5A5_0001;
    settle();
    check_eq("wr_gnt", host_gnt, 1'b1);
    check_eq("wr_mem_we", mem_we, 1'b1);
    check_eq("wr_mem_addr", mem_addr, 32'h10);
    step();
    host_we = 1'b0; host_wdata = '0;
    settle();
    check_eq("rd_gnt", host_gnt, 1'b1);
    check_eq("rd_mem_we", mem_we, 1'b0);
    check_eq("wr_no_rvalid", host_rvalid, 1'b0);
    step();
    host_req = 1'b0;
    check_eq("rd_rvalid", host_rvalid, 1'b1);
    check_eq("rd_rdata", host_rdata, 32'hA5A5_0001);
    step();
    check_eq("rd_rvalid_drop", host_rvalid, 1'b0);
    check_eq("idle_no_req_we", mem_we, 1'b0);

    // go -> ARM for exactly one cycle, then RUN
    go = 1'b1;
    step();
    go = 1'b0;
    check_eq("arm_state", dbg_state, ARM);
    check_eq("arm_start", cpu_start, 1'b1);
    check_eq("arm_busy", busy, 1'b1);
    check_eq("arm_cpu_reset", cpu_reset, 1'b0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'hDEAD;
    settle();
    check_eq("arm_gnt", host_gnt, 1'b0);
    step();
    check_eq("run_state", dbg_state, RUN);
    check_eq("run_start_low", cpu_start, 1'b0);
    check_eq("run_gnt", host_gnt, 1'b0);
    check_eq("run_hostwr_blocked", mem_we, 1'b0);
    host_req = 1'b0; host_we = 1'b0;

    // RUN cycle 1: model CPU writes 0x1234 to 0x20
    cpu_mem_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
    settle();
    check_eq("cpu_mem_we", mem_we, 1'b1);
    check_eq("cpu_mem_addr", mem_addr, 32'h20);
    check_eq("cpu_mem_wdata", mem_wdata, 32'h1234);
    step();                              // RUN cycle 2
    cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    go = 1'b1;                           // ignored while busy
    step();                              // RUN cycle 3
    go = 1'b0;
    check_eq("go_busy_ignored", dbg_state, RUN);
    step_n(37);                          // RUN cycle 40
    check_eq("run40_state", dbg_state, RUN);
    cpu_flag_zero = 1'b1;
    step();
    cpu_flag_zero = 1'b0;
    check_done_state("flag", 1'b0);
    check_eq("flag_x10_kept", ram[8'h10], 32'hA5A5_0001);

    // Host reads CPU result in DONE
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    settle();
    check_eq("done_rd_gnt", host_gnt, 1'b1);
    step();
    host_req = 1'b0;
    check_eq("done_rvalid", host_rvalid, 1'b1);
    check_eq("done_rdata", host_rdata, 32'h1234);
    step();

    // Watchdog run: flag never set
    go = 1'b1;
    step();
    go = 1'b0;
    step();                              // RUN cycle 1
    step_n(MAXC - 1);                    // RUN cycle MAXC
    check_eq("wd_pre_state", dbg_state, RUN);
`ifdef SEQ_WATCHDOG_EN
    step();
    check_done_state("wd", 1'b1);
`else
    step_n(4);
    check_eq("nowd_still_run", dbg_state, RUN);
    check_eq("nowd_timeout", timeout, 1'b0);
    cpu_flag_zero = 1'b1;
    step();
    cpu_flag_zero = 1'b0;
    check_done_state("nowd", 1'b0);
`endif

    // go and host_req together in DONE: go wins, done/timeout cleared
    go = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'hBEEF;
    settle();
    check_eq("go_req_gnt", host_gnt, 1'b0);
    check_eq("go_req_mem_we", mem_we, 1'b0);
    step();
    go = 1'b0; host_req = 1'b0; host_we = 1'b0;
    check_eq("go_req_state", dbg_state, ARM);
    check_eq("go_req_done", done, 1'b0);
    check_eq("go_req_timeout", timeout, 1'b0);
    check_eq("go_req_rvalid", host_rvalid, 1'b0);
    step();                              // RUN cycle 1
    step_n(MAXC - 1);                    // RUN cycle MAXC: flag with expiry
    cpu_flag_zero = 1'b1;
    step();
    cpu_flag_zero = 1'b0;
    check_done_state("tie", 1'b0);
    check_eq("tie_ram10", ram[8'h10], 32'hA5A5_0001);

    // Reset mid-RUN
    go = 1'b1;
    step();
    go = 1'b0;
    step_n(5);
    check_eq("mid_state", dbg_state, RUN);
    cpu_mem_write = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h77;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_mem_write = 1'b0;
    check_eq("mrst_state", dbg_state, IDLE);
    check_eq("mrst_cpu_reset", cpu_reset, 1'b1);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_done", done, 1'b0);
    check_eq("mrst_timeout", timeout, 1'b0);
    check_eq("mrst_mem_we", mem_we, 1'b0);
    check_eq("mrst_rvalid", host_rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_run_sequencer.md
# rsa_run_sequencer

Top-level run controller for the RSA pipeline CPU. It holds the CPU in reset while a host loads operands into the shared data memory, then releases and starts the CPU and gives it exclusive memory ownership. When the program signals completion on FlagZero, or the watchdog expires, it hands the memory back to the host for result readout. It sits between the CPU's data-memory port, the host port and the single-port synchronous data RAM.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- MAX_CYCLES, 1000000, watchdog limit in RUN cycles (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- go  in  1  host run request, sampled in IDLE/DONE
- host_req  in  1  host memory access request
- host_we  in  1  host write enable (qualified by host_req)
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host_rdata valid (read accepted previous cycle)
- host_rdata  out  DATA_W  read data to host
- busy  out  1  CPU owns memory (ARM or RUN)
- done  out  1  run finished, sticky until next go
- timeout  out  1  last run ended by watchdog, sticky until next go
- cpu_reset  out  1  reset to CPU
- cpu_start  out  1  start pulse to CPU
- cpu_flag_zero  in  1  CPU completion flag (FlagZero)
- cpu_mem_write, cpu_addr, cpu_wdata  in  1/ADDR_W/DATA_W  CPU memory port (MemWrite, ALUResult, WriteData)
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  to data RAM
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency

## Operation
- FSM states are IDLE, ARM, RUN and DONE. Reset enters IDLE.
- IDLE:
  - cpu_reset=1; host owns the RAM.
  - go=1 → ARM, and the watchdog counter is cleared.
- ARM (exactly 1 cycle):
  - cpu_reset=0 and cpu_start=1.
  - Next state is RUN.
- RUN:
  - cpu_reset=0; the CPU memory port is muxed to the RAM and host_gnt=0.
  - cpu_flag_zero=1 → DONE with done=1.
  - If the counter reaches MAX_CYCLES-1 without the flag → DONE with done=1 and timeout=1.
  - Flag and expiry in the same cycle: flag wins, timeout=0.
- DONE:
  - cpu_reset=1 (CPU frozen); host owns the RAM.
  - go=1 → ARM; this clears done and timeout.
- Host access (IDLE/DONE):
  - host_gnt = host_req, combinational; it is 0 when go=1 in the same cycle (go wins).
  - Granted write: mem_we=1.
  - Granted read: host_rvalid=1 next cycle, with host_rdata=mem_rdata.
- In ARM/RUN, mem_we follows cpu_mem_write. In IDLE/DONE with no grant, mem_we=0 and the address/data mux points at the host port.
- go while busy is ignored.
- Reset mid-RUN → IDLE immediately: cpu_reset=1, done=0, timeout=0, and no rvalid is pending.

## Timing
- Reset values: host_gnt=0, host_rvalid=0, host_rdata=0, busy=0, done=0, timeout=0, cpu_reset=1, cpu_start=0, mem_we=0.
- go sampled at edge N: ARM during N+1 (cpu_start high for 1 cycle), RUN from N+2.
- Flag sampled in RUN at edge M: done=1 and state DONE from M+1.
- Memory ownership switches on the same edge as the state change, so no RAM cycle is shared.
- Host read latency is 1 cycle, back-to-back accepted.
- Watchdog counter is $clog2(MAX_CYCLES) bits wide, increments once per RUN cycle and never wraps.

## Configuration
- SEQ_WATCHDOG_EN defined: watchdog counter and timeout output behave as above.
- SEQ_WATCHDOG_EN undefined: no counter; RUN exits only on cpu_flag_zero or reset, and timeout is tied to 0.

## Structure
- Package rsa_seq_pkg holds:
  - the state enum seq_state_t {IDLE, ARM, RUN, DONE};
  - default widths ADDR_W_DEF and DATA_W_DEF.
- One natural sub-module: mem_port_mux, the combinational CPU/host RAM mux selected by a `cpu_owns` signal. The FSM, watchdog and rvalid register stay in the top.

## Test plan
- Host writes 0xA5A5_0001 to addr 0x10, then reads it back in IDLE → host_gnt=1 both cycles; rvalid one cycle later with rdata=0xA5A5_0001.
- go at cycle 5 → cpu_start=1 only at cycle 6; busy=1 from cycle 6; host_req during RUN gets host_gnt=0.
- Model CPU writes 0x1234 to 0x20 and raises cpu_flag_zero after 40 RUN cycles → done=1 next cycle, cpu_reset=1; host read of 0x20 returns 0x1234.
- MAX_CYCLES=16, flag never set → timeout=1 and done=1 after exactly 16 RUN cycles. Same run with the flag set on cycle 16 → timeout=0.
- go and host_req asserted together in DONE → host_gnt=0, state ARM, done and timeout cleared.
- reset asserted mid-RUN → next cycle: IDLE, cpu_reset=1, busy=0, done=0, mem_we=0.
